// File: rtl/icebus_status_rx.sv
// 8N1 UART receiver and status-frame parser for the motor bus.
// Emits one validated status update per good 17-byte frame; bad frames are dropped and counted.
module icebus_status_rx #(
    parameter int CLOCK_SPEED_HZ   = 50_000_000,
    parameter int BAUD_RATE        = 1_000_000,
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int TIMEOUT_BYTES    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    output logic        status_valid,
    output logic [7:0]  status_motor,
    output logic [31:0] status_position,
    output logic [31:0] status_velocity,
    output logic [15:0] status_current,
    output logic [31:0] status_displacement,
    output logic        frame_error,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
);
    localparam int CPB      = CLOCK_SPEED_HZ / BAUD_RATE;
    localparam int CW       = $clog2(CPB);
    localparam int TO_LIMIT = TIMEOUT_BYTES * 10 * CPB;
    localparam int TW       = $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
    typedef enum logic [1:0] {P_HUNT, P_ID, P_PAYLOAD, P_CHECK} pstate_t;

    logic [1:0] sync;
    logic       rx_s;

    always_ff @(posedge clock) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], rx};
    end
    assign rx_s = sync[1];

    // ---------------- byte receiver ----------------
    bstate_t       bstate, bstate_nx;
    logic [CW-1:0] bcnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          half_pt, bit_pt, byte_done, byte_err;

    assign half_pt   = (bcnt == CW'(CPB / 2 - 1));
    assign bit_pt    = (bcnt == CW'(CPB - 1));
    assign byte_done = (bstate == B_STOP) && bit_pt && rx_s;
    assign byte_err  = (bstate == B_STOP) && bit_pt && !rx_s;

    always_ff @(posedge clock) begin
        if (reset) bstate <= B_IDLE;
        else       bstate <= bstate_nx;
    end

    always_comb begin
        bstate_nx = bstate;
        case (bstate)
            B_IDLE:  if (!rx_s) bstate_nx = B_START;
            B_START: if (half_pt) bstate_nx = rx_s ? B_IDLE : B_DATA;
            B_DATA:  if (bit_pt && bit_idx == 3'd7) bstate_nx = B_STOP;
            B_STOP:  if (bit_pt) bstate_nx = B_IDLE;
        endcase
    end

    // Counter restarts at the half-bit point so every later sample lands mid-bit.
    always_ff @(posedge clock) begin
        if (reset) begin
            bcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (bstate == B_IDLE || (bstate == B_START && half_pt) || bit_pt) bcnt <= '0;
            else                                                              bcnt <= bcnt + 1'b1;
            if (bstate == B_START) bit_idx <= '0;
            else if (bstate == B_DATA && bit_pt) bit_idx <= bit_idx + 1'b1;
            if (bstate == B_DATA && bit_pt) shreg <= {rx_s, shreg[7:1]};
        end
    end

    // ---------------- frame parser ----------------
    pstate_t       pstate, pstate_nx;
    logic [3:0]    pidx;
    logic [7:0]    sum, motor;
    logic          bad_id;
    logic [111:0]  payload;
    logic [TW-1:0] to_cnt;
    logic          timeout, good, bad;

    assign timeout = (pstate != P_HUNT) && !byte_done && !byte_err && (to_cnt == TW'(TO_LIMIT - 1));

    always_ff @(posedge clock) begin
        if (reset) pstate <= P_HUNT;
        else       pstate <= pstate_nx;
    end

    // good/bad are mutually exclusive, so status_valid and frame_error never coincide.
    always_comb begin
        pstate_nx = pstate;
        good      = 1'b0;
        bad       = 1'b0;
        if (byte_err) begin
            pstate_nx = P_HUNT;
            bad       = 1'b1;
        end else if (timeout) begin
            pstate_nx = P_HUNT;
            bad       = 1'b1;
        end else if (byte_done) begin
            case (pstate)
                P_HUNT:    if (shreg == 8'hA5) pstate_nx = P_ID;
                P_ID:      pstate_nx = P_PAYLOAD;
                P_PAYLOAD: if (pidx == 4'd13) pstate_nx = P_CHECK;
                P_CHECK: begin
                    pstate_nx = P_HUNT;
                    if (!bad_id && shreg == sum) good = 1'b1;
                    else                         bad  = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pidx                <= '0;
            sum                 <= '0;
            motor               <= '0;
            bad_id              <= 1'b0;
            payload             <= '0;
            to_cnt              <= '0;
            status_valid        <= 1'b0;
            frame_error         <= 1'b0;
            status_motor        <= '0;
            status_position     <= '0;
            status_velocity     <= '0;
            status_current      <= '0;
            status_displacement <= '0;
            frame_count         <= '0;
            error_count         <= '0;
        end else begin
            status_valid <= good;
            frame_error  <= bad;
            if (pstate == P_HUNT || byte_done || byte_err) to_cnt <= '0;
            else                                           to_cnt <= to_cnt + 1'b1;
            if (byte_done) begin
                case (pstate)
                    P_ID: begin
                        motor  <= shreg;
                        bad_id <= ({1'b0, shreg} >= 9'(NUMBER_OF_MOTORS));
                        sum    <= shreg;
                        pidx   <= '0;
                    end
                    P_PAYLOAD: begin
                        payload <= {payload[103:0], shreg};
                        sum     <= sum + shreg;
                        pidx    <= pidx + 1'b1;
                    end
                    default: ;
                endcase
            end
            if (good) begin
                status_motor        <= motor;
                status_position     <= payload[111:80];
                status_velocity     <= payload[79:48];
                status_current      <= payload[47:32];
                status_displacement <= payload[31:0];
                if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
            end
            if (bad && error_count != 16'hFFFF) error_count <= error_count + 16'd1;
        end
    end
endmodule
